sobel_frame_ctrl: RTL

Frame-level sequencer for the Sobel edge-detection pipeline. It runs three phases per frame: load a binary image into the external frame memory, issue 3x3 window origins to the Sobel kernel, and forward the kernel's edge bits to the result writer with line and frame markers. It replaces the ad-hoc start/end phase flags with a clocked FSM and valid/ready handshakes, and it sits between the pixel source, frame RAM, kernel and writer.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_raster_cnt.sv | 43 ++++
 rtl/sobel_frame_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: default frame geometry, derived
// address/row/column widths and the frame sequencer state encoding.
package sobel_pkg;

  localparam int IMG_W = 512;
  localparam int IMG_H = 512;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW = width_of(IMG_W * IMG_H);
  localparam int RW = width_of(IMG_H);
  localparam int CW = width_of(IMG_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_raster_cnt.sv
// Row/column raster counter, column fastest. Holds at the terminal position
// and raises finished once the terminal position itself has been advanced past.
module sobel_raster_cnt #(
  parameter int COLS = 2,
  parameter int ROWS = 2,
  parameter int CW   = 1,
  parameter int RW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last,
  output logic          finished
);

  logic last_row;

  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign last     = last_col & last_row;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col      <= '0;
      row      <= '0;
      finished <= 1'b0;
    end else if (advance && !finished) begin
      if (last) begin
        finished <= 1'b1;
      end else if (last_col) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: loads a binary image into frame RAM, issues 3x3 window
// origins to the kernel and forwards edge bits to the writer with row/frame markers.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int  IMG_W = sobel_pkg::IMG_W,
  parameter int  IMG_H = sobel_pkg::IMG_H,
  localparam int AW    = width_of(IMG_W * IMG_H),
  localparam int RW    = width_of(IMG_H),
  localparam int CW    = width_of(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pix,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wdata,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  input  logic          k_valid,
  output logic          k_ready,
  input  logic          k_edge,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_eol,
  output logic          out_eof,
  output state_t        state
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and payload is held
  // stable by the sender until the transfer completes.

  localparam int NPIX = IMG_W * IMG_H;
  localparam int OW   = IMG_W - 2;
  localparam int OH   = IMG_H - 2;

  logic [AW-1:0] load_cnt;
  logic          comp;
  logic          clear;
  logic          load_fire;
  logic          load_last;
  logic          win_fire;
  logic          res_fire;
  logic          iss_finished;
  logic          iss_last_col;
  logic          iss_last;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic          res_last_col;
  logic          res_last;
  logic          res_finished;
  logic          unused_cnt;

  assign comp  = (state == COMP);
  assign clear = (state == IDLE) && start;

  // Frame RAM write port is a direct decode of the pixel handshake.
  assign load_fire = in_ready & in_valid;
  assign load_last = (load_cnt == AW'(NPIX - 1));
  assign mem_we    = load_fire;
  assign mem_waddr = load_cnt;
  assign mem_wdata = in_pix;

  assign win_valid = comp & ~iss_finished;
  assign win_fire  = win_valid & win_ready;

  // Result path is a combinational passthrough, only opened in COMP.
  assign out_valid = comp & ~res_finished & k_valid;
  assign k_ready   = comp & ~res_finished & out_ready;
  assign out_bit   = comp & k_edge;
  assign out_eol   = comp & res_last_col;
  assign out_eof   = comp & res_last;
  assign res_fire  = out_valid & out_ready;

  assign unused_cnt = ^{iss_last_col, iss_last, res_row, res_col};

  sobel_raster_cnt #(
    .COLS(OW),
    .ROWS(OH),
    .CW  (CW),
    .RW  (RW)
  ) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (win_fire),
    .col     (win_col),
    .row     (win_row),
    .last_col(iss_last_col),
    .last    (iss_last),
    .finished(iss_finished)
  );

  sobel_raster_cnt #(
    .COLS(OW),
    .ROWS(OH),
    .CW  (CW),
    .RW  (RW)
  ) u_result_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (res_fire),
    .col     (res_col),
    .row     (res_row),
    .last_col(res_last_col),
    .last    (res_last),
    .finished(res_finished)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      load_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          if (load_fire) begin
            // The terminal address is kept rather than wrapped past.
            if (load_last) begin
              state    <= COMP;
              in_ready <= 1'b0;
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
        end
        COMP: begin
          if (res_fire && res_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
